rbb_upload_arbiter: RTL and testbench
=====================================

// Module: rbb_upload_arbiter
// PURPOSE
//  Shares one host write-request channel among NUM_RBB result batch buffers, one per PE array.
//  Each requester holds req_valid for a full batch of 2^LINE_IDX_WIDTH lines and presents one line at a time.
//  The arbiter grants one buffer round-robin, locks the grant for the whole batch, and forwards each line as a write request.
//  Each write address is base + slot + line. An ack pulse advances the requester to its next line.
// PARAMETERS
//  NUM_RBB         4    number of result batch buffers (2..16)
//  LINE_IDX_WIDTH  8    line index width; a batch is 2^LINE_IDX_WIDTH lines
//  DATA_WIDTH      512  line width in bits
//  ADDR_WIDTH      32   host cache-line address width
// PORTS
//  clk              in   1                       core clock
//  reset            in   1                       synchronous, active-high reset
//  rbb_req_valid    in   NUM_RBB                 per-buffer batch-ready flag
//  rbb_line_idx     in   NUM_RBB*LINE_IDX_WIDTH  per-buffer current line index, buffer i at [i*W +: W]
//  rbb_data         in   NUM_RBB*DATA_WIDTH      per-buffer current line data
//  rbb_ack          out  NUM_RBB                 one-cycle accept pulse to the granted buffer
//  result_base_addr in   ADDR_WIDTH              host result region base, in cache lines
//  wr_almost_full   in   1                       host write channel backpressure
//  wr_req_valid     out  1                       write request strobe
//  wr_req_addr      out  ADDR_WIDTH              write cache-line address
//  wr_req_data      out  DATA_WIDTH              write data
//  batch_done       out  1                       one-cycle pulse when a batch's last line is sent
//  batch_done_idx   out  $clog2(NUM_RBB)         buffer index for batch_done
// BEHAVIOUR
//  Reset: state=ARB, rr_ptr=0, grant=0. Every output is 0.
//  A reset mid-batch abandons the batch. Requesters are reset by the same reset.
//  FSM states: ARB, SEND, RELEASE.
//   ARB: if any rbb_req_valid is set, grant the first set bit searching from rr_ptr upward with wrap, then go to SEND.
//        Otherwise stay in ARB.
//   SEND: a line is accepted in a cycle when rbb_req_valid[grant] & ~wr_almost_full.
//    - In that cycle rbb_ack[grant]=1 (combinational).
//    - Also in that cycle, register the write request:
//      wr_req_valid=1 next cycle, wr_req_data = granted line data,
//      wr_req_addr = result_base_addr + (grant << LINE_IDX_WIDTH) + line_idx, computed modulo 2^ADDR_WIDTH.
//    - Write latency is 1 cycle, ack to request. Back-to-back accepts are allowed, giving 1 line/cycle.
//    - The requester presents its next line in the cycle after an ack.
//    - If the line was idx == 2^LINE_IDX_WIDTH-1, go to RELEASE.
//    - If valid is low or wr_almost_full is high: no ack, wr_req_valid=0 next cycle, grant held.
//   RELEASE: batch_done=1 and batch_done_idx=grant, both registered one cycle after the last write.
//    - rr_ptr = (grant+1) mod NUM_RBB. Go to ARB.
//    - No ack is issued in this state, so the finishing buffer can drop its valid before re-arbitration.
//  rbb_ack is never issued to a non-granted buffer and never in ARB or RELEASE. At most one bit is set per cycle.
//  If wr_almost_full rises in the same cycle a line is offered, that line is not accepted. The channel absorbs writes already in flight.
//  If all buffers are valid, the grant order from reset is 0,1,2,3,0. No buffer waits more than NUM_RBB-1 batches.
//  A granted valid that drops mid-batch is an error: hold the grant and wait, with no timeout.
//  result_base_addr is sampled on every accept. Software changes it only while idle.
// CONFIGURATION
//  RBB_ARB_PERF_EN defined: add output ports perf_lines [31:0] and perf_stall [31:0].
//   - perf_lines counts accepted lines.
//   - perf_stall counts SEND cycles with the granted valid high and wr_almost_full high.
//   - Both clear on reset and saturate at 2^32-1.
//  RBB_ARB_PERF_EN undefined: the counter logic is absent, and perf_lines/perf_stall are driven to constant 0.
// TESTING
//  1 Single buffer, base=0x1000, buf2 valid, lines 0..255, no backpressure
//    -> 256 writes on consecutive cycles at addresses 0x1200..0x12FF.
//    -> batch_done pulses once with idx=2, one cycle after the last write.
//  2 All 4 valid from reset
//    -> full batches granted in order 0,1,2,3, then 0.
//    -> no ack interleaving between buffers, and ack is one-hot every cycle.
//  3 wr_almost_full held high for 5 cycles at line 0x40
//    -> no ack and no wr_req_valid for those 5 cycles.
//    -> line 0x40 is written exactly once after the release. perf_stall=5 with RBB_ARB_PERF_EN.
//  4 buf1 finishes while buf1 and buf3 are both still valid in the RELEASE cycle
//    -> the next grant is buf3 and buf1 is not re-granted.
//  5 Reset asserted at line 0x80 of a batch
//    -> next cycle: all outputs are 0, state=ARB, rr_ptr=0.
//    -> after release, a new batch from line 0 is written correctly.
//  6 base=0xFFFFFF00, grant 3, line 0xFF
//    -> wr_req_addr wraps to 0x000002FF.

Source files
------------

// File: rtl/rbb_upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rbb_upload_arbiter
// Brief    : Round-robin arbiter that shares one host write-request channel
//            among NUM_RBB result batch buffers. A grant is locked for a whole
//            batch of 2^LINE_IDX_WIDTH lines, and each accepted line becomes a
//            write request one cycle later.
//            Optional macro RBB_ARB_PERF_EN adds the perf_lines / perf_stall
//            counters. When the macro is undefined both ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rbb_upload_arbiter #(
    parameter int NUM_RBB        = 4,
    parameter int LINE_IDX_WIDTH = 8,
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_RBB-1:0]                 rbb_req_valid,
    input  logic [NUM_RBB*LINE_IDX_WIDTH-1:0]  rbb_line_idx,
    input  logic [NUM_RBB*DATA_WIDTH-1:0]      rbb_data,
    output logic [NUM_RBB-1:0]                 rbb_ack,
    input  logic [ADDR_WIDTH-1:0]              result_base_addr,
    input  logic                               wr_almost_full,
    output logic                               wr_req_valid,
    output logic [ADDR_WIDTH-1:0]              wr_req_addr,
    output logic [DATA_WIDTH-1:0]              wr_req_data,
    output logic                               batch_done,
    output logic [$clog2(NUM_RBB)-1:0]         batch_done_idx,
    output logic [31:0]                        perf_lines,
    output logic [31:0]                        perf_stall
);

    localparam int IDX_W = $clog2(NUM_RBB);
    localparam logic [LINE_IDX_WIDTH-1:0] LAST_LINE = '1;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          grant;
    logic [IDX_W-1:0]          rr_ptr;

    logic                      pick_found;
    logic [IDX_W-1:0]          pick_idx;
    logic [IDX_W-1:0]          cand;
    logic                      grant_valid;
    logic [LINE_IDX_WIDTH-1:0] grant_line;
    logic [DATA_WIDTH-1:0]     grant_data;
    logic                      accept;

    // Round-robin search: first requesting buffer at or after rr_ptr, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_RBB; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_RBB);
            if (!pick_found && rbb_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the granted buffer's current line index and data.
    always_comb begin
        grant_line = '0;
        grant_data = '0;
        for (int k = 0; k < NUM_RBB; k++) begin
            if (grant == IDX_W'(k)) begin
                grant_line = rbb_line_idx[k*LINE_IDX_WIDTH +: LINE_IDX_WIDTH];
                grant_data = rbb_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_valid = rbb_req_valid[grant];
    // A line is taken only while sending, with the owner valid and room downstream.
    assign accept      = (state == ST_SEND) && grant_valid && !wr_almost_full;

    // Combinational ack, only ever to the granted buffer.
    always_comb begin
        rbb_ack = '0;
        for (int k = 0; k < NUM_RBB; k++) begin
            rbb_ack[k] = accept && (grant == IDX_W'(k));
        end
    end

    // Arbitration FSM with registered write-request and batch-done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_ARB;
            grant          <= '0;
            rr_ptr         <= '0;
            wr_req_valid   <= 1'b0;
            wr_req_addr    <= '0;
            wr_req_data    <= '0;
            batch_done     <= 1'b0;
            batch_done_idx <= '0;
        end else begin
            wr_req_valid <= 1'b0;
            batch_done   <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        wr_req_valid <= 1'b1;
                        wr_req_data  <= grant_data;
                        // Each buffer owns a 2^LINE_IDX_WIDTH-line slot; wraps modulo 2^ADDR_WIDTH.
                        wr_req_addr  <= result_base_addr
                                        + (ADDR_WIDTH'(grant) << LINE_IDX_WIDTH)
                                        + ADDR_WIDTH'(grant_line);
                        if (grant_line == LAST_LINE) begin
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    // One idle cycle lets the finished buffer drop valid before re-arbitration.
                    batch_done     <= 1'b1;
                    batch_done_idx <= grant;
                    rr_ptr         <= (grant == IDX_W'(NUM_RBB - 1)) ? '0 : grant + 1'b1;
                    state          <= ST_ARB;
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

`ifdef RBB_ARB_PERF_EN
    logic stall_cycle;
    assign stall_cycle = (state == ST_SEND) && grant_valid && wr_almost_full;

    // Saturating counters for accepted lines and backpressure stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lines <= '0;
            perf_stall <= '0;
        end else begin
            if (accept && (perf_lines != 32'hFFFF_FFFF)) begin
                perf_lines <= perf_lines + 32'd1;
            end
            if (stall_cycle && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    assign perf_lines = '0;
    assign perf_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rbb_upload_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rbb_upload_arbiter
// Brief    : Self-checking bench for rbb_upload_arbiter. Requesters are
//            modelled as line counters; a transaction-level reference predicts
//            ack, write requests, batch_done and perf counters every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rbb_upload_arbiter;

    localparam int N     = 4;
    localparam int LW    = 8;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int IW    = 2;
    localparam int BATCH = 1 << LW;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      rbb_req_valid;
    logic [N*LW-1:0]   rbb_line_idx;
    logic [N*DW-1:0]   rbb_data;
    logic [N-1:0]      rbb_ack;
    logic [AW-1:0]     result_base_addr;
    logic              wr_almost_full;
    logic              wr_req_valid;
    logic [AW-1:0]     wr_req_addr;
    logic [DW-1:0]     wr_req_data;
    logic              batch_done;
    logic [IW-1:0]     batch_done_idx;
    logic [31:0]       perf_lines;
    logic [31:0]       perf_stall;

    rbb_upload_arbiter #(
        .NUM_RBB(N), .LINE_IDX_WIDTH(LW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .rbb_req_valid(rbb_req_valid), .rbb_line_idx(rbb_line_idx), .rbb_data(rbb_data),
        .rbb_ack(rbb_ack), .result_base_addr(result_base_addr),
        .wr_almost_full(wr_almost_full),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .batch_done(batch_done), .batch_done_idx(batch_done_idx),
        .perf_lines(perf_lines), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] line_data(input int b, input int l);
        return {8'(b), 24'(l), 32'(b * 977 + l * 131) ^ 32'hA5C3_0000};
    endfunction

    // ---------------- requester models ----------------
    int         r_idx  [N];
    bit         r_val  [N];
    bit         r_keep [N];
    int         r_drop [N];
    bit         rand_mode = 1'b0;
    logic [N-1:0] ack_s;
    logic       rst_s;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            rbb_req_valid[i]           = r_val[i] && (r_drop[i] == 0);
            rbb_line_idx[i*LW +: LW]   = LW'(r_idx[i]);
            rbb_data[i*DW +: DW]       = line_data(i, r_idx[i]);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_idx[i] = 0; r_val[i] = 0; r_keep[i] = 0; r_drop[i] = 0;
        end
        wr_almost_full = 1'b0;
        drive_inputs();
    endtask

    // One clock: sample ack before the edge, update requesters just after it.
    task automatic cycle();
        @(negedge clk);
        ack_s = rbb_ack;
        rst_s = reset;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rst_s) begin
                r_idx[i] = 0;
            end else if (ack_s[i]) begin
                if (r_idx[i] == BATCH - 1) begin
                    r_idx[i] = 0;
                    r_val[i] = r_keep[i];
                    if (rand_mode) r_keep[i] = $urandom_range(0, 1) == 1;
                end else begin
                    r_idx[i] = r_idx[i] + 1;
                end
            end
            if (r_drop[i] > 0) r_drop[i] = r_drop[i] - 1;
            if (rand_mode) begin
                if (!r_val[i] && $urandom_range(0, 15) == 0) begin
                    r_val[i]  = 1'b1;
                    r_keep[i] = $urandom_range(0, 1) == 1;
                end
                if (r_val[i] && r_drop[i] == 0 && $urandom_range(0, 199) == 0)
                    r_drop[i] = $urandom_range(1, 4);
            end
        end
        if (rand_mode) wr_almost_full = ($urandom_range(0, 7) == 0);
        drive_inputs();
    endtask

    // ---------------- reference model + compare ----------------
    typedef struct { int cyc; logic [AW-1:0] addr; } wrec_t;
    typedef struct { int cyc; int idx; } brec_t;
    wrec_t wlog[$];
    brec_t blog[$];

    bit            mon_on   = 1'b0;
    int            mcyc     = 0;
    int            m_owner  = -1;   // buffer holding the channel, -1 while arbitrating
    bit            m_rel    = 1'b0; // batch finished, one quiet cycle pending
    int            m_ptr    = 0;
    bit            exp_wv   = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    bit            exp_bd   = 1'b0;
    int            exp_bdi  = 0;
    longint        exp_lines = 0;
    longint        exp_stall = 0;

    always @(negedge clk) begin
        logic [N-1:0] eack;
        int           oidx;
        if (mon_on) begin
            mcyc++;
            eack = '0;
            oidx = 0;
            if (m_owner >= 0) oidx = int'(rbb_line_idx[m_owner*LW +: LW]);
            if (m_owner >= 0 && !m_rel && rbb_req_valid[m_owner] && !wr_almost_full)
                eack[m_owner] = 1'b1;

            chk("ack", 64'(rbb_ack), 64'(eack));
            chk("wr_req_valid", 64'(wr_req_valid), 64'(exp_wv));
            if (exp_wv) begin
                chk("wr_req_addr", 64'(wr_req_addr), 64'(exp_addr));
                chk("wr_req_data", 64'(wr_req_data), 64'(exp_data));
            end
            chk("batch_done", 64'(batch_done), 64'(exp_bd));
            if (exp_bd) chk("batch_done_idx", 64'(batch_done_idx), 64'(exp_bdi));
`ifdef RBB_ARB_PERF_EN
            chk("perf_lines", 64'(perf_lines), 64'(exp_lines));
            chk("perf_stall", 64'(perf_stall), 64'(exp_stall));
`else
            chk("perf_lines_off", 64'(perf_lines), 64'd0);
            chk("perf_stall_off", 64'(perf_stall), 64'd0);
`endif
            if (wr_req_valid === 1'b1) wlog.push_back('{mcyc, wr_req_addr});
            if (batch_done === 1'b1)   blog.push_back('{mcyc, int'(batch_done_idx)});

            if (reset) begin
                m_owner = -1; m_rel = 0; m_ptr = 0;
                exp_wv = 0; exp_bd = 0; exp_lines = 0; exp_stall = 0;
            end else begin
                exp_wv = (eack != '0);
                exp_bd = 1'b0;
                if (exp_wv) begin
                    exp_addr = AW'(longint'(result_base_addr) + longint'(m_owner * BATCH) + longint'(oidx));
                    exp_data = line_data(m_owner, oidx);
                    if (exp_lines < 64'hFFFF_FFFF) exp_lines++;
                end
                if (m_owner >= 0 && !m_rel && rbb_req_valid[m_owner] && wr_almost_full)
                    if (exp_stall < 64'hFFFF_FFFF) exp_stall++;
                if (m_rel) begin
                    exp_bd  = 1'b1;
                    exp_bdi = m_owner;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_rel   = 1'b0;
                end else if (m_owner < 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (m_owner < 0 && rbb_req_valid[(m_ptr + k) % N])
                            m_owner = (m_ptr + k) % N;
                    end
                end else if (exp_wv && oidx == BATCH - 1) begin
                    m_rel = 1'b1;
                end
            end
        end
    end

    // ---------------- test helpers ----------------
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        wlog.delete();
        blog.delete();
    endtask

    task automatic run_until_bd(input string nm, input int count, input int budget);
        int target;
        int b;
        target = blog.size() + count;
        b = 0;
        while (blog.size() < target && b < budget) begin
            cycle();
            b++;
        end
        if (blog.size() < target) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got %0d batch_done pulses expected %0d", nm, blog.size(), target);
        end
    endtask

    task automatic run_until_line(input string nm, input int b, input int line, input int budget);
        int n;
        n = 0;
        while (r_idx[b] != line && n < budget) begin
            cycle();
            n++;
        end
        if (r_idx[b] != line) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: line %0d expected %0d", nm, r_idx[b], line);
        end
    endtask

    int cnt;

    initial begin
        reset            = 1'b1;
        result_base_addr = '0;
        clear_reqs();
        @(posedge clk);
        #1;
        mon_on = 1'b1;

        // 1: single buffer 2, base 0x1000
        result_base_addr = 32'h0000_1000;
        clear_reqs();
        r_val[2] = 1'b1;
        drive_inputs();
        do_reset(2);
        clear_logs();
        run_until_bd("t1", 1, 400);
        chk("t1_write_count", 64'(wlog.size()), 64'd256);
        if (wlog.size() == 256 && blog.size() >= 1) begin
            chk("t1_first_addr", 64'(wlog[0].addr), 64'h1200);
            chk("t1_last_addr", 64'(wlog[255].addr), 64'h12FF);
            chk("t1_consecutive", 64'(wlog[255].cyc - wlog[0].cyc), 64'd255);
            chk("t1_done_latency", 64'(blog[0].cyc - wlog[255].cyc), 64'd1);
            chk("t1_done_idx", 64'(blog[0].idx), 64'd2);
        end
        repeat (4) cycle();
        chk("t1_single_done", 64'(blog.size()), 64'd1);

        // 2: all four valid from reset
        result_base_addr = 32'h0002_0000;
        clear_reqs();
        for (int i = 0; i < N; i++) begin r_val[i] = 1'b1; r_keep[i] = 1'b1; end
        drive_inputs();
        do_reset(2);
        clear_logs();
        run_until_bd("t2", 5, 5 * 300);
        if (blog.size() >= 5) begin
            chk("t2_order0", 64'(blog[0].idx), 64'd0);
            chk("t2_order1", 64'(blog[1].idx), 64'd1);
            chk("t2_order2", 64'(blog[2].idx), 64'd2);
            chk("t2_order3", 64'(blog[3].idx), 64'd3);
            chk("t2_order4", 64'(blog[4].idx), 64'd0);
        end

        // 3: backpressure for 5 cycles at line 0x40
        result_base_addr = 32'h0;
        clear_reqs();
        r_val[0] = 1'b1;
        drive_inputs();
        do_reset(2);
        clear_logs();
        run_until_line("t3", 0, 8'h40, 300);
        wr_almost_full = 1'b1;
        repeat (5) cycle();
        wr_almost_full = 1'b0;
        run_until_bd("t3", 1, 400);
        cnt = 0;
        foreach (wlog[i]) if (wlog[i].addr == 32'h40) cnt++;
        chk("t3_line40_once", 64'(cnt), 64'd1);
        chk("t3_write_count", 64'(wlog.size()), 64'd256);
`ifdef RBB_ARB_PERF_EN
        chk("t3_perf_stall", 64'(perf_stall), 64'd5);
        chk("t3_perf_lines", 64'(perf_lines), 64'd256);
`endif

        // 4: buf1 stays valid across its release, buf3 waiting
        clear_reqs();
        r_val[1] = 1'b1; r_keep[1] = 1'b1;
        r_val[3] = 1'b1;
        drive_inputs();
        do_reset(2);
        clear_logs();
        run_until_bd("t4", 2, 700);
        if (blog.size() >= 2) begin
            chk("t4_first", 64'(blog[0].idx), 64'd1);
            chk("t4_second", 64'(blog[1].idx), 64'd3);
        end

        // 5: reset in the middle of a batch
        clear_reqs();
        r_val[0] = 1'b1;
        drive_inputs();
        do_reset(2);
        run_until_line("t5", 0, 8'h80, 300);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t5_rst_wr_valid", 64'(wr_req_valid), 64'd0);
        chk("t5_rst_addr", 64'(wr_req_addr), 64'd0);
        chk("t5_rst_done", 64'(batch_done), 64'd0);
        chk("t5_rst_ack", 64'(rbb_ack), 64'd0);
        clear_logs();
        run_until_bd("t5", 1, 400);
        chk("t5_write_count", 64'(wlog.size()), 64'd256);
        if (wlog.size() >= 1 && blog.size() >= 1) begin
            chk("t5_first_addr", 64'(wlog[0].addr), 64'h0);
            chk("t5_done_idx", 64'(blog[0].idx), 64'd0);
        end

        // 6: address wrap
        result_base_addr = 32'hFFFF_FF00;
        clear_reqs();
        r_val[3] = 1'b1;
        drive_inputs();
        do_reset(2);
        clear_logs();
        run_until_bd("t6", 1, 400);
        if (wlog.size() == 256) begin
            chk("t6_first_addr", 64'(wlog[0].addr), 64'h0000_0200);
            chk("t6_wrap_addr", 64'(wlog[255].addr), 64'h0000_02FF);
        end

        // Random traffic: arrivals, backpressure and transient valid drops
        result_base_addr = 32'($urandom);
        clear_reqs();
        do_reset(2);
        rand_mode = 1'b1;
        repeat (6000) cycle();
        rand_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
